// File: rtl/arm_defs_pkg.sv
// Shared definitions for the MEM-stage SRAM responder: state encodings,
// the CPU address of SRAM half-word 0, and the SRAM data width.
`timescale 1ns/1ps
package arm_defs;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    LO2  = 3'd3,
    HI2  = 3'd4,
    DONE = 3'd5
  } sram_state_e;

  localparam logic [31:0] MEM_BASE_ADDR = 32'd1024;
  localparam int          SRAM_DATA_W   = 16;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable 4-bit down-counter that times one half-word access.
// It stops at zero, and done is high while the count is zero.
`timescale 1ns/1ps
module sram_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       done
);

  // load takes priority; otherwise count down and hold at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage responder that serves 32-bit loads/stores from a 16-bit async SRAM
// using two half-word accesses (low half at the even address, high at the odd).
// Optional build macro SRAM_READ64_EN: loads also fetch the following word and
// return 64 bits.
//
// state | meaning
// IDLE  | waiting for mem_r_en/mem_w_en; request and operands latched here
// LO    | low half-word access of the addressed word
// HI    | high half-word access of the addressed word
// LO2   | low half-word of the next word (64-bit loads only)
// HI2   | high half-word of the next word (64-bit loads only)
// DONE  | one-cycle ready pulse, then back to IDLE
`timescale 1ns/1ps
module sram_controller
  import arm_defs::*;
#(
  parameter int          WAIT_CYCLES = 3,
  parameter int          SRAM_ADDR_W = 18,
  parameter logic [31:0] BASE_ADDR   = MEM_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
`ifdef SRAM_READ64_EN
  output logic [63:0]            read_data,
`else
  output logic [31:0]            read_data,
`endif
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] sram_dq,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n
);

  localparam int         OFF_W    = SRAM_ADDR_W - 1;
  localparam logic [3:0] LOAD_VAL = 4'(WAIT_CYCLES - 1);
`ifdef SRAM_READ64_EN
  localparam int         BUF_W    = 48;
`else
  localparam int         BUF_W    = 16;
`endif

  sram_state_e            state;
  logic                   is_store;
  logic [OFF_W-1:0]       off_q;
  logic [15:0]            wdata_hi_q;
  logic [15:0]            wdata_half;
  logic                   drive;
  logic [BUF_W-1:0]       rd_buf;
  logic                   cnt_load;
  logic [3:0]             cnt_count;
  logic                   cnt_done;
  logic                   req;
  logic [31:0]            off_in;
  logic                   unused_off;

  assign req        = mem_r_en | mem_w_en;
  assign off_in     = address - BASE_ADDR;
  assign unused_off = ^{off_in[31:SRAM_ADDR_W+1], off_in[1:0]};

`ifdef SRAM_READ64_EN
  logic [OFF_W-1:0] off_nxt;
  assign off_nxt = off_q + OFF_W'(1);
`endif

  // the only bus driver; released whenever no store half is active
  assign sram_dq = drive ? wdata_half : {SRAM_DATA_W{1'bz}};

  assign ready = ((state == IDLE) & ~mem_r_en & ~mem_w_en) | (state == DONE);

  // reload the timer on every entry into an access half
  always_comb begin
    cnt_load = 1'b0;
    case (state)
      IDLE:    cnt_load = req;
      LO:      cnt_load = cnt_done;
`ifdef SRAM_READ64_EN
      HI:      cnt_load = cnt_done & ~is_store;
      LO2:     cnt_load = cnt_done;
`endif
      default: cnt_load = 1'b0;
    endcase
  end

  sram_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .count    (cnt_count),
    .done     (cnt_done)
  );

  // sequencing FSM with registered SRAM pins and load data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      is_store   <= 1'b0;
      off_q      <= '0;
      wdata_hi_q <= 16'd0;
      wdata_half <= 16'd0;
      drive      <= 1'b0;
      rd_buf     <= '0;
      read_data  <= '0;
      sram_addr  <= '0;
      sram_we_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state      <= LO;
            is_store   <= mem_w_en;
            off_q      <= off_in[SRAM_ADDR_W:2];
            wdata_hi_q <= write_data[31:16];
            wdata_half <= write_data[15:0];
            drive      <= mem_w_en;
            sram_we_n  <= ~mem_w_en;
            sram_addr  <= {off_in[SRAM_ADDR_W:2], 1'b0};
          end
        end
        LO: begin
          if (cnt_done) begin
            state      <= HI;
            sram_addr  <= {off_q, 1'b1};
            wdata_half <= wdata_hi_q;
            sram_we_n  <= ~is_store;
            if (!is_store) rd_buf[15:0] <= sram_dq;
          end else if (cnt_count == 4'd1) begin
            // last cycle of the half: strobe high, data still held
            sram_we_n <= 1'b1;
          end
        end
        HI: begin
          if (cnt_done) begin
            drive     <= 1'b0;
            sram_we_n <= 1'b1;
            if (is_store) begin
              state <= DONE;
            end else begin
`ifdef SRAM_READ64_EN
              state          <= LO2;
              rd_buf[31:16]  <= sram_dq;
              sram_addr      <= {off_nxt, 1'b0};
`else
              state     <= DONE;
              read_data <= {sram_dq, rd_buf};
`endif
            end
          end else if (cnt_count == 4'd1) begin
            sram_we_n <= 1'b1;
          end
        end
`ifdef SRAM_READ64_EN
        LO2: begin
          if (cnt_done) begin
            state          <= HI2;
            sram_addr      <= {off_nxt, 1'b1};
            rd_buf[47:32]  <= sram_dq;
          end
        end
        HI2: begin
          if (cnt_done) begin
            state     <= DONE;
            read_data <= {sram_dq, rd_buf};
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
